usb_tx_pkt_ctrl: RTL and testbench
==================================

# usb_tx_pkt_ctrl

Parametrised USB transmit packet controller, successor to the fixed 64-byte TX controller. It sequences SYNC, PID, a variable-length payload from the TX FIFO, the CRC16 bytes and EOP into the byte transmitter and bit stuffer. Over the fixed controller it adds:
- runtime payload length, including zero-length packets;
- selectable ACK/NAK/STALL handshakes;
- automatic DATA0/DATA1 toggle tracking;
- abort.

## Interface
Parameters:
- MAX_BYTES, 64, largest payload in bytes; longer requests are clamped to this value.
- LEN_W, $clog2(MAX_BYTES+1), width of length and counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- send_hs  in  1  request handshake packet; sampled in IDLE only
- hs_sel  in  2  handshake type: 0 ACK, 1 NAK, 2 STALL, 3 reserved (treated as NAK)
- send_data  in  1  request data packet; sampled in IDLE only
- data_len  in  LEN_W  payload byte count; latched with send_data
- ack_rcvd  in  1  pulse from RXPU: last data packet was ACKed
- toggle_rst  in  1  force toggle to DATA0 (SETUP / configuration)
- tx_abort  in  1  abandon current packet
- byte_done  in  1  one-cycle pulse from byte transmitter: current byte finished and the next byte was sampled from the mux
- tx_byte  out  8  controller-sourced byte (SYNC/PID)
- load_en  out  1  start byte transmitter with first byte of packet
- select  out  2  byte mux: 00 FIFO, 01 tx_byte, 10 CRC[15:8], 11 CRC[7:0]
- fifo_r_enable  out  1  advance FIFO head one byte
- calc_crc  out  1  CRC unit accumulates bytes currently on the mux
- crc_reset  out  1  clear CRC unit
- eop  out  1  drive SE0 for EOP
- is_txing  out  1  keeps RXPU idle
- data_toggle  out  1  current data PID: 0 = DATA0, 1 = DATA1
- pkt_done  out  1  one-cycle pulse when the controller returns to IDLE

## Operation
- PIDs are encoded {~pid, pid}: ACK 8'hD2, NAK 8'h5A, STALL 8'h1E, DATA0 8'hC3, DATA1 8'h4B. SYNC is 8'h80.
- Request priority: send_hs wins over send_data when both are high. Requests outside IDLE are ignored.

States and transitions:
- IDLE: accept a request; latch hs_sel, or latch min(data_len, MAX_BYTES) into remaining count. Next state LOAD_SYNC.
- LOAD_SYNC: tx_byte=SYNC, load_en=1. Next state WAIT_SYNC.
- WAIT_SYNC: tx_byte = PID (handshake PID, or DATA0/DATA1 from the toggle). Leave on byte_done:
  - handshake packet → WAIT_HS_PID;
  - data packet → WAIT_PID.
- WAIT_HS_PID: on byte_done → EOP1.
- WAIT_PID: select=00.
  - On byte_done with count>0 → QUEUE.
  - On byte_done with count=0 (zero-length packet) → CRC_LO.
- QUEUE: fifo_r_enable=1 for one cycle, calc_crc=1, decrement count. Next state WAIT_DATA.
- WAIT_DATA: calc_crc=1. On byte_done:
  - count>0 → QUEUE;
  - count=0 → CRC_LO.
- CRC_LO: select=11. On byte_done → CRC_HI.
- CRC_HI: select=10. On byte_done → EOP1.
- EOP1, EOP2: eop=1. Next states EOP2, then TX_END.
- TX_END: is_txing=1, crc_reset=1. Next state IDLE with pkt_done=1.

Other behaviour:
- crc_reset=1 in IDLE, LOAD_SYNC, WAIT_SYNC and TX_END; 0 elsewhere.
- is_txing=1 in every state except IDLE.
- Select is 01 wherever it is not stated above.
- Toggle: flips on ack_rcvd only in IDLE, and only when the last packet sent was data. toggle_rst clears it to 0 and wins over ack_rcvd in the same cycle.
- tx_abort in any non-IDLE state forces EOP1 on the next cycle. The remaining count is cleared and the toggle is unchanged. tx_abort in IDLE has no effect.
- Reset: state IDLE, count 0, data_toggle 0, select 01, tx_byte 8'h80, crc_reset 1. All other outputs are 0.

## Timing
- Request sampled in IDLE: load_en pulses 1 cycle later; SYNC is the first byte on the wire.
- Each FIFO byte gets exactly one fifo_r_enable, 1 cycle after the byte_done that consumed the previous byte.
- Packet of N data bytes:
  - N fifo_r_enable pulses;
  - N+4 byte_done pulses from SYNC to EOP1 (SYNC, PID, N data, 2 CRC);
  - eop high exactly 2 cycles;
  - pkt_done 3 cycles after the final byte_done.
- Handshake packet: 2 byte_done pulses, then EOP.
- All outputs are Moore, registered state decode; no output depends combinationally on inputs.

## Structure
- Package usb_tx_pkg holds:
  - PID localparams and SYNC_BYTE;
  - SEL_* mux encodings;
  - hs_sel encodings;
  - the state enum tx_state_t.
- Sub-module usb_tx_byte_cnt: a LEN_W down-counter with load, decrement and zero flag, instantiated once.

## Test plan
- Reset mid-packet (in WAIT_DATA) → all outputs at reset values immediately; data_toggle=0.
- send_hs, hs_sel=2 → bytes 8'h80, 8'h1E, then eop 2 cycles; no fifo_r_enable; pkt_done pulses.
- send_data, data_len=3, toggle=0 → 8'h80, 8'hC3, 3 FIFO bytes, CRC lo then hi, eop; 3 fifo_r_enable pulses.
- Then ack_rcvd, then data_len=0 → PID 8'h4B directly followed by CRC bytes; zero fifo_r_enable pulses.
- data_len=MAX_BYTES+5 → exactly MAX_BYTES fifo_r_enable pulses. Same cycle send_hs and send_data → handshake sent, data ignored.
- tx_abort after second data byte → eop on next cycle, no CRC select; toggle_rst together with ack_rcvd → data_toggle=0.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared encodings for the USB transmit packet controller: PIDs, byte-mux selects,
// handshake selects and the controller state type.
package usb_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // PIDs go on the wire as {~pid, pid}
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [1:0] SEL_FIFO   = 2'b00;
    localparam logic [1:0] SEL_TXBYTE = 2'b01;
    localparam logic [1:0] SEL_CRC_HI = 2'b10;
    localparam logic [1:0] SEL_CRC_LO = 2'b11;

    localparam logic [1:0] HS_ACK   = 2'd0;
    localparam logic [1:0] HS_NAK   = 2'd1;
    localparam logic [1:0] HS_STALL = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_SYNC,
        ST_WAIT_SYNC,
        ST_WAIT_HS_PID,
        ST_WAIT_PID,
        ST_QUEUE,
        ST_WAIT_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP1,
        ST_EOP2,
        ST_TX_END
    } tx_state_t;

    // The reserved handshake code falls back to NAK.
    function automatic logic [7:0] hs_pid(input logic [1:0] sel);
        case (sel)
            HS_ACK:   hs_pid = PID_ACK;
            HS_STALL: hs_pid = PID_STALL;
            default:  hs_pid = PID_NAK;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_byte_cnt.sv
// Remaining-payload down-counter: load has priority over decrement, and the
// count saturates at zero.
module usb_tx_byte_cnt #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [LEN_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// USB TX packet sequencer: SYNC, PID, runtime-length payload, CRC16 and EOP,
// with handshake packets, DATA0/DATA1 toggle tracking and abort.
module usb_tx_pkt_ctrl
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             send_hs,
    input  logic [1:0]       hs_sel,
    input  logic             send_data,
    input  logic [LEN_W-1:0] data_len,
    input  logic             ack_rcvd,
    input  logic             toggle_rst,
    input  logic             tx_abort,
    input  logic             byte_done,
    output logic [7:0]       tx_byte,
    output logic             load_en,
    output logic [1:0]       select,
    output logic             fifo_r_enable,
    output logic             calc_crc,
    output logic             crc_reset,
    output logic             eop,
    output logic             is_txing,
    output logic             data_toggle,
    output logic             pkt_done,
    output tx_state_t        dbg_state
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    tx_state_t        state_q, state_d;
    logic             is_hs_q, is_hs_d;
    logic [1:0]       hs_sel_q, hs_sel_d;
    logic             last_data_q, last_data_d;
    logic             toggle_q, toggle_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [LEN_W-1:0] cnt_val;

    usb_tx_byte_cnt #(.LEN_W(LEN_W)) u_byte_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        is_hs_d     = is_hs_q;
        hs_sel_d    = hs_sel_q;
        last_data_d = last_data_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send_hs) begin
                    is_hs_d     = 1'b1;
                    hs_sel_d    = hs_sel;
                    last_data_d = 1'b0;
                    state_d     = ST_LOAD_SYNC;
                end else if (send_data) begin
                    is_hs_d     = 1'b0;
                    last_data_d = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_val     = (data_len > MAX_LEN) ? MAX_LEN : data_len;
                    state_d     = ST_LOAD_SYNC;
                end
            end
            ST_LOAD_SYNC:   state_d = ST_WAIT_SYNC;
            ST_WAIT_SYNC:   if (byte_done) state_d = is_hs_q ? ST_WAIT_HS_PID : ST_WAIT_PID;
            ST_WAIT_HS_PID: if (byte_done) state_d = ST_EOP1;
            ST_WAIT_PID:    if (byte_done) state_d = cnt_zero ? ST_CRC_LO : ST_QUEUE;
            ST_QUEUE: begin
                cnt_dec = 1'b1;
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA:   if (byte_done) state_d = cnt_zero ? ST_CRC_LO : ST_QUEUE;
            ST_CRC_LO:      if (byte_done) state_d = ST_CRC_HI;
            ST_CRC_HI:      if (byte_done) state_d = ST_EOP1;
            ST_EOP1:        state_d = ST_EOP2;
            ST_EOP2:        state_d = ST_TX_END;
            ST_TX_END:      state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        // Abort still ends the packet with a proper EOP so the bus returns to idle.
        if (tx_abort && (state_q != ST_IDLE)) begin
            state_d  = ST_EOP1;
            cnt_load = 1'b1;
            cnt_val  = '0;
            cnt_dec  = 1'b0;
        end
    end

    always_comb begin
        toggle_d = toggle_q;
        if (toggle_rst) begin
            toggle_d = 1'b0;
        end else if ((state_q == ST_IDLE) && ack_rcvd && last_data_q) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            is_hs_q     <= 1'b0;
            hs_sel_q    <= HS_ACK;
            last_data_q <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_hs_q     <= is_hs_d;
            hs_sel_q    <= hs_sel_d;
            last_data_q <= last_data_d;
            toggle_q    <= toggle_d;
        end
    end

    // Moore output decode: everything derives from registered state only.
    always_comb begin
        tx_byte       = SYNC_BYTE;
        load_en       = 1'b0;
        select        = SEL_TXBYTE;
        fifo_r_enable = 1'b0;
        calc_crc      = 1'b0;
        crc_reset     = 1'b0;
        eop           = 1'b0;
        pkt_done      = 1'b0;
        is_txing      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:      crc_reset = 1'b1;
            ST_LOAD_SYNC: begin
                load_en   = 1'b1;
                crc_reset = 1'b1;
            end
            ST_WAIT_SYNC: begin
                crc_reset = 1'b1;
                tx_byte   = is_hs_q ? hs_pid(hs_sel_q) : (toggle_q ? PID_DATA1 : PID_DATA0);
            end
            ST_WAIT_PID:  select = SEL_FIFO;
            ST_QUEUE: begin
                fifo_r_enable = 1'b1;
                calc_crc      = 1'b1;
            end
            ST_WAIT_DATA: calc_crc = 1'b1;
            ST_CRC_LO:    select = SEL_CRC_LO;
            ST_CRC_HI:    select = SEL_CRC_HI;
            ST_EOP1,
            ST_EOP2:      eop = 1'b1;
            ST_TX_END: begin
                crc_reset = 1'b1;
                pkt_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign data_toggle = toggle_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Directed plus randomized bench for usb_tx_pkt_ctrl; a byte-transmitter stand-in
// drives byte_done and a packet-level model predicts PIDs, mux order and pulse counts.
module tb_usb_tx_pkt_ctrl;
  import usb_tx_pkg::*;

  localparam int MAX_BYTES = 8;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);
  localparam int BUDGET    = 500;

  logic             clk;
  logic             n_rst;
  logic             send_hs;
  logic [1:0]       hs_sel;
  logic             send_data;
  logic [LEN_W-1:0] data_len;
  logic             ack_rcvd;
  logic             toggle_rst;
  logic             tx_abort;
  logic             byte_done;
  logic [7:0]       tx_byte;
  logic             load_en;
  logic [1:0]       select;
  logic             fifo_r_enable;
  logic             calc_crc;
  logic             crc_reset;
  logic             eop;
  logic             is_txing;
  logic             data_toggle;
  logic             pkt_done;
  tx_state_t        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Expected / observed mux select at every byte_done of one packet
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  bit model_toggle    = 1'b0;
  bit model_last_data = 1'b0;

  usb_tx_pkt_ctrl #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .send_hs       (send_hs),
    .hs_sel        (hs_sel),
    .send_data     (send_data),
    .data_len      (data_len),
    .ack_rcvd      (ack_rcvd),
    .toggle_rst    (toggle_rst),
    .tx_abort      (tx_abort),
    .byte_done     (byte_done),
    .tx_byte       (tx_byte),
    .load_en       (load_en),
    .select        (select),
    .fifo_r_enable (fifo_r_enable),
    .calc_crc      (calc_crc),
    .crc_reset     (crc_reset),
    .eop           (eop),
    .is_txing      (is_txing),
    .data_toggle   (data_toggle),
    .pkt_done      (pkt_done),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {tx_byte, load_en, select, fifo_r_enable, calc_crc, crc_reset, eop, is_txing, data_toggle, pkt_done},
          {8'h80, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // One-cycle ack/toggle_rst pulse while idle, then check the toggle against the model
  task automatic pulse_ctrl(input bit ack, input bit trst);
    @(negedge clk);
    ack_rcvd   = ack;
    toggle_rst = trst;
    if (trst) model_toggle = 1'b0;
    else if (ack && model_last_data) model_toggle = ~model_toggle;
    @(negedge clk);
    ack_rcvd   = 1'b0;
    toggle_rst = 1'b0;
    check("data_toggle", data_toggle, model_toggle);
  endtask

  // Runs one packet end to end; abort_bd>0 aborts two cycles after that byte_done
  task automatic run_pkt(input bit do_hs, input bit do_data, input logic [1:0] hs_v,
                         input int len_v, input int abort_bd);
    bit         hs_pkt;
    int         n;
    logic [7:0] exp_pid;
    int         cyc, bd_cnt, fifo_cnt, eop_cyc, done_cnt;
    int         load_cyc, next_bd, last_bd_cyc, done_cyc, abort_cyc, eop_first;
    logic [7:0] pid_obs, load_byte;
    bit         eop_seen, crc_sel_seen;
    logic [1:0] o;

    hs_pkt = do_hs;
    n = (len_v > MAX_BYTES) ? MAX_BYTES : len_v;
    if (hs_pkt) exp_pid = (hs_v == 2'd0) ? 8'hD2 : (hs_v == 2'd2) ? 8'h1E : 8'h5A;
    else        exp_pid = model_toggle ? 8'h4B : 8'hC3;
    exp_q.delete();
    obs_q.delete();
    if (hs_pkt) begin
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b01);
    end else begin
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b00);
      for (int i = 0; i < n; i++) exp_q.push_back(2'b01);
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b10);
    end
    cyc = 0; bd_cnt = 0; fifo_cnt = 0; eop_cyc = 0; done_cnt = 0;
    load_cyc = -1; next_bd = -1; last_bd_cyc = -1; done_cyc = -1; abort_cyc = -1; eop_first = -1;
    pid_obs = 8'h00; load_byte = 8'h00; eop_seen = 1'b0; crc_sel_seen = 1'b0;

    @(negedge clk);
    send_hs   = do_hs;
    send_data = do_data;
    hs_sel    = hs_v;
    data_len  = LEN_W'(len_v);
    while (done_cnt == 0 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      send_hs = 1'b0; send_data = 1'b0; byte_done = 1'b0; tx_abort = 1'b0;
      if (load_en) begin
        load_cyc  = cyc;
        load_byte = tx_byte;
        next_bd   = cyc + int'($urandom_range(3, 6));
      end
      if (fifo_r_enable) fifo_cnt++;
      if (select == SEL_CRC_LO || select == SEL_CRC_HI) crc_sel_seen = 1'b1;
      if (eop) begin
        eop_cyc++;
        if (!eop_seen) eop_first = cyc;
        eop_seen = 1'b1;
      end
      if (pkt_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!eop_seen && next_bd == cyc) begin
        byte_done = 1'b1;
        bd_cnt++;
        last_bd_cyc = cyc;
        obs_q.push_back(select);
        if (bd_cnt == 1) pid_obs = tx_byte;
        if (abort_bd != 0 && bd_cnt == abort_bd) abort_cyc = cyc + 2;
        next_bd = cyc + int'($urandom_range(3, 6));
      end
      if (cyc == abort_cyc) tx_abort = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      if (pkt_done) done_cnt++;
    end
    check("pkt_timeout", (cyc < BUDGET), 1);
    check("load_latency", load_cyc, 1);
    check("sync_byte", load_byte, 8'h80);
    check("pid_byte", pid_obs, exp_pid);
    if (abort_bd != 0) begin
      check("abort_bd_count", bd_cnt, abort_bd);
      check("abort_eop_next", eop_first, abort_cyc + 1);
      check("abort_no_crc_sel", crc_sel_seen, 0);
    end else begin
      check("bd_count", bd_cnt, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        o = (i < obs_q.size()) ? obs_q[i] : 2'bxx;
        check($sformatf("select_at_bd%0d", i), o, exp_q[i]);
      end
      check("fifo_r_count", fifo_cnt, hs_pkt ? 0 : n);
      check("eop_after_last_bd", eop_first - last_bd_cyc, 1);
      check("done_after_last_bd", done_cyc - last_bd_cyc, 3);
    end
    check("eop_cycles", eop_cyc, 2);
    check("pkt_done_pulses", done_cnt, 1);
    check("idle_is_txing", is_txing, 0);
    model_last_data = !hs_pkt;
  endtask

  initial begin : stimulus
    int bd, nb, rst_at, cyc;
    n_rst = 1'b0;
    send_hs = 1'b0; hs_sel = 2'd0; send_data = 1'b0; data_len = '0;
    ack_rcvd = 1'b0; toggle_rst = 1'b0; tx_abort = 1'b0; byte_done = 1'b0;
    #22;
    check_reset_vals("reset_values");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_reset_vals("idle_after_reset");

    // STALL handshake
    run_pkt(1'b1, 1'b0, 2'd2, 0, 0);
    // 3-byte DATA0 packet, then ack flips to DATA1
    run_pkt(1'b0, 1'b1, 2'd0, 3, 0);
    pulse_ctrl(1'b1, 1'b0);
    // zero-length DATA1 packet
    run_pkt(1'b0, 1'b1, 2'd0, 0, 0);
    pulse_ctrl(1'b1, 1'b0);
    // oversize request clamps to MAX_BYTES
    run_pkt(1'b0, 1'b1, 2'd0, MAX_BYTES + 5, 0);
    // both requests together: handshake (ACK) wins
    run_pkt(1'b1, 1'b1, 2'd0, 4, 0);
    // ack after a handshake leaves the toggle alone; reserved hs_sel sends NAK
    pulse_ctrl(1'b1, 1'b0);
    run_pkt(1'b1, 1'b0, 2'd3, 0, 0);
    run_pkt(1'b0, 1'b1, 2'd0, 2, 0);
    pulse_ctrl(1'b1, 1'b0);
    // abort after the second data byte; toggle untouched, then toggle_rst beats ack
    run_pkt(1'b0, 1'b1, 2'd0, 5, 4);
    pulse_ctrl(1'b0, 1'b0);
    pulse_ctrl(1'b1, 1'b1);

    // randomized packets and toggle traffic
    repeat (12) begin
      if ($urandom_range(0, 2) == 0) run_pkt(1'b1, 1'b0, 2'($urandom_range(0, 3)), 0, 0);
      else run_pkt(1'b0, 1'b1, 2'd0, int'($urandom_range(0, MAX_BYTES + 3)), 0);
      pulse_ctrl(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    end

    // make sure the toggle is 1 before the mid-packet reset
    run_pkt(1'b0, 1'b1, 2'd0, 1, 0);
    if (!model_toggle) pulse_ctrl(1'b1, 1'b0);
    else begin
      run_pkt(1'b0, 1'b1, 2'd0, 1, 0);
      pulse_ctrl(1'b0, 1'b0);
    end

    // reset in WAIT_DATA: third byte_done, then two cycles later
    @(negedge clk);
    send_data = 1'b1;
    data_len  = LEN_W'(3);
    bd = 0; nb = -1; rst_at = -1; cyc = 0;
    while (rst_at < 0 || cyc < rst_at) begin
      @(negedge clk);
      cyc++;
      send_data = 1'b0; byte_done = 1'b0;
      if (load_en) nb = cyc + 3;
      if (cyc == nb) begin
        byte_done = 1'b1;
        bd++;
        nb = cyc + 3;
        if (bd == 3) rst_at = cyc + 2;
      end
      if (cyc > BUDGET) begin
        check("mid_reset_timeout", cyc, 0);
        break;
      end
    end
    n_rst = 1'b0;
    #1;
    check_reset_vals("mid_packet_reset");
    model_toggle = 1'b0;
    model_last_data = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    run_pkt(1'b0, 1'b1, 2'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
